// File: rtl/u_mem_arb_pkg.sv
// Shared types and constants for the unified-SRAM fetch/LSU arbiter.
package u_mem_arb_pkg;

   typedef enum logic {
      ARB = 1'b0,  // normal arbitration, LSU has priority
      IFP = 1'b1   // forced-fetch, fetch wins if requesting
   } arb_st_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      IF   = 2'd1,
      LS   = 2'd2
   } rsp_tag_t;

   localparam logic [3:0] MEM_RE_WORD = 4'hF;
   localparam logic [3:0] SC_SAT      = 4'hF;

endpackage

// File: rtl/u_arb_starve.sv
// Fetch starvation tracker: counts consecutive denied fetch cycles and
// raises if_prio for one arbitration round once the limit is reached.
module u_arb_starve
   import u_mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic if_req,
   input  logic if_gnt,
   output logic if_prio
);

   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   arb_st_t    st, st_next;
   logic [3:0] sc, sc_next;

   // Starve count: grows only while fetch waits, saturating at 15.
   always_comb begin
      sc_next = sc;
      if (!if_req || if_gnt)
         sc_next = 4'd0;
      else if (sc != SC_SAT)
         sc_next = sc + 4'd1;
   end

   // Next state: enter forced-fetch when the count reaches the limit,
   // leave as soon as fetch is served or withdraws.
   always_comb begin
      st_next = st;
      case (st)
         ARB: if (sc_next >= SMAX) st_next = IFP;
         IFP: if (if_gnt || !if_req) st_next = ARB;
         default: st_next = ARB;
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st <= ARB;
         sc <= 4'd0;
      end else begin
         st <= st_next;
         sc <= sc_next;
      end
   end

   assign if_prio = (st == IFP);

endmodule

// File: rtl/u_mem_arb.sv
// Fetch/LSU arbiter for one single-port synchronous SRAM. One access per
// cycle, LSU preferred, fetch starvation bounded by u_arb_starve.
module u_mem_arb
   import u_mem_arb_pkg::*;
#(
   parameter int AW         = 16,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_a,
   input  logic          if_kill,
   output logic          if_gnt,
   output logic          if_rvld,
   output logic [DW-1:0] if_rd,
   input  logic          ls_req,
   input  logic [AW-1:0] ls_a,
   input  logic [3:0]    ls_we,
   input  logic [DW-1:0] ls_wd,
   input  logic [3:0]    ls_re,
   output logic          ls_gnt,
   output logic          ls_rvld,
   output logic [DW-1:0] ls_rd,
   output logic [AW-1:0] mem_a,
   output logic          mem_e,
   output logic [3:0]    mem_we,
   output logic [DW-1:0] mem_wd,
   output logic [3:0]    mem_re,
   input  logic [DW-1:0] mem_rd
);

   logic     if_prio;
   rsp_tag_t rt, rt_next;

   u_arb_starve #(.STARVE_MAX(STARVE_MAX)) starve (
      .clk     (clk),
      .rst     (rst),
      .if_req  (if_req),
      .if_gnt  (if_gnt),
      .if_prio (if_prio)
   );

   // Grant selection: fetch wins when forced or when the LSU is idle.
   always_comb begin
      if_gnt = if_req && (if_prio || !ls_req);
      ls_gnt = ls_req && !if_gnt;
   end

   // SRAM port mux: zero-cycle pass-through of the winner, idle otherwise.
   always_comb begin
      mem_e  = 1'b0;
      mem_a  = '0;
      mem_we = 4'h0;
      mem_wd = '0;
      mem_re = 4'h0;
      if (if_gnt) begin
         mem_e  = 1'b1;
         mem_a  = if_a;
         mem_re = MEM_RE_WORD;
      end else if (ls_gnt) begin
         mem_e  = 1'b1;
         mem_a  = ls_a;
         mem_we = ls_we;
         mem_wd = ls_wd;
         mem_re = ls_re;
      end
   end

   // Response tag: who owns next cycle's mem_rd. Write-only LSU accesses
   // produce nothing to return.
   always_comb begin
      rt_next = NONE;
      if (if_gnt)
         rt_next = IF;
      else if (ls_gnt && (ls_re != 4'h0))
         rt_next = LS;
   end

   // Tag register; reset drops any response in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rt <= NONE;
      else
         rt <= rt_next;
   end

   // A kill only hides the old fetch response; it never touches grants.
   assign if_rvld = (rt == IF) && !if_kill;
   assign ls_rvld = (rt == LS);
   assign if_rd   = mem_rd;
   assign ls_rd   = mem_rd;

endmodule

// File: tb/tb_u_mem_arb.sv
// Directed self-checking bench for u_mem_arb.
module tb_u_mem_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_kill, ls_req;
   logic [15:0] if_a, ls_a;
   logic [3:0]  ls_we, ls_re;
   logic [31:0] ls_wd, mem_rd;
   logic        if_gnt, if_rvld, ls_gnt, ls_rvld, mem_e;
   logic [31:0] if_rd, ls_rd, mem_wd;
   logic [15:0] mem_a;
   logic [3:0]  mem_we, mem_re;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   u_mem_arb #(.AW(16), .DW(32), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_a(if_a), .if_kill(if_kill),
      .if_gnt(if_gnt), .if_rvld(if_rvld), .if_rd(if_rd),
      .ls_req(ls_req), .ls_a(ls_a), .ls_we(ls_we), .ls_wd(ls_wd), .ls_re(ls_re),
      .ls_gnt(ls_gnt), .ls_rvld(ls_rvld), .ls_rd(ls_rd),
      .mem_a(mem_a), .mem_e(mem_e), .mem_we(mem_we), .mem_wd(mem_wd),
      .mem_re(mem_re), .mem_rd(mem_rd)
   );

   // Advance to just after the next rising edge; inputs change here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      if_req = 0; if_kill = 0; ls_req = 0;
      if_a = '0; ls_a = '0; ls_we = '0; ls_wd = '0; ls_re = '0;
   endtask

   task automatic test_reset();
      idle();
      mem_rd = '0;
      rst = 1;
      tick(); tick();
      #1;
      checks++; if (if_rvld !== 1'b0) begin failures++; $display("FAIL reset_if_rvld got=%b exp=0", if_rvld); end
      checks++; if (ls_rvld !== 1'b0) begin failures++; $display("FAIL reset_ls_rvld got=%b exp=0", ls_rvld); end
      checks++; if ({if_gnt, ls_gnt} !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", {if_gnt, ls_gnt}); end
      checks++; if ({mem_e, mem_a, mem_we, mem_re} !== 25'd0) begin failures++; $display("FAIL reset_mem got e=%b a=%h we=%h re=%h exp all 0", mem_e, mem_a, mem_we, mem_re); end
      rst = 0;
      tick();
   endtask

   task automatic test_fetch_alone();
      if_req = 1; if_a = 16'h0010;
      #1;
      checks++; if ({if_gnt, ls_gnt} !== 2'b10) begin failures++; $display("FAIL fetch_gnt got=%b exp=10", {if_gnt, ls_gnt}); end
      checks++; if (mem_a !== 16'h0010) begin failures++; $display("FAIL fetch_mem_a got=%h exp=0010", mem_a); end
      checks++; if ({mem_e, mem_re, mem_we} !== 9'b1_1111_0000) begin failures++; $display("FAIL fetch_mem_ctl got e=%b re=%h we=%h exp e=1 re=f we=0", mem_e, mem_re, mem_we); end
      tick();
      if_req = 0; mem_rd = 32'hDEAD_0010;
      #1;
      checks++; if (if_rvld !== 1'b1) begin failures++; $display("FAIL fetch_rvld got=%b exp=1", if_rvld); end
      checks++; if (if_rd !== 32'hDEAD_0010) begin failures++; $display("FAIL fetch_rd got=%h exp=dead0010", if_rd); end
      checks++; if (ls_rvld !== 1'b0) begin failures++; $display("FAIL fetch_ls_rvld got=%b exp=0", ls_rvld); end
      tick();
      checks++; if (if_rvld !== 1'b0) begin failures++; $display("FAIL fetch_rvld_drop got=%b exp=0", if_rvld); end
   endtask

   task automatic test_ls_priority();
      if_req = 1; if_a = 16'h0020;
      ls_req = 1; ls_a = 16'h0200; ls_re = 4'hF; ls_we = 4'h0;
      #1;
      checks++; if ({if_gnt, ls_gnt} !== 2'b01) begin failures++; $display("FAIL prio_gnt got=%b exp=01", {if_gnt, ls_gnt}); end
      checks++; if ({mem_a, mem_re} !== {16'h0200, 4'hF}) begin failures++; $display("FAIL prio_mem got a=%h re=%h exp a=0200 re=f", mem_a, mem_re); end
      tick();
      idle(); mem_rd = 32'h0BAD_0200;
      #1;
      checks++; if ({ls_rvld, if_rvld} !== 2'b10) begin failures++; $display("FAIL prio_rvld got ls=%b if=%b exp ls=1 if=0", ls_rvld, if_rvld); end
      checks++; if (ls_rd !== 32'h0BAD_0200) begin failures++; $display("FAIL prio_ls_rd got=%h exp=0bad0200", ls_rd); end
      tick();
   endtask

   // With both requesters held: four LSU grants, then a forced fetch,
   // then the LSU again.
   task automatic starve_run(input string tag);
      logic [1:0] exp [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
      if_req = 1; if_a = 16'h0030;
      ls_req = 1; ls_a = 16'h0400; ls_re = 4'hF;
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++;
         if ({if_gnt, ls_gnt} !== exp[i]) begin
            failures++;
            $display("FAIL %s_cyc%0d gnt got=%b exp=%b", tag, i, {if_gnt, ls_gnt}, exp[i]);
         end
         tick();
      end
      idle();
      tick();
   endtask

   task automatic test_starve();
      starve_run("starve");
   endtask

   task automatic test_write();
      ls_req = 1; ls_a = 16'h0300; ls_we = 4'b0011; ls_re = 4'h0; ls_wd = 32'h1234_5678;
      #1;
      checks++; if (ls_gnt !== 1'b1) begin failures++; $display("FAIL write_gnt got=%b exp=1", ls_gnt); end
      checks++; if ({mem_e, mem_we, mem_re} !== 9'b1_0011_0000) begin failures++; $display("FAIL write_mem_ctl got e=%b we=%b re=%h exp e=1 we=0011 re=0", mem_e, mem_we, mem_re); end
      checks++; if ({mem_a, mem_wd} !== {16'h0300, 32'h1234_5678}) begin failures++; $display("FAIL write_mem_data got a=%h wd=%h exp a=0300 wd=12345678", mem_a, mem_wd); end
      tick();
      idle();
      #1;
      checks++; if ({ls_rvld, if_rvld} !== 2'b00) begin failures++; $display("FAIL write_no_rvld got ls=%b if=%b exp 0 0", ls_rvld, if_rvld); end
      tick();
   endtask

   task automatic test_kill();
      if_req = 1; if_a = 16'h0040;
      tick();
      if_kill = 1; if_a = 16'h0044;
      #1;
      checks++; if (if_rvld !== 1'b0) begin failures++; $display("FAIL kill_rvld got=%b exp=0", if_rvld); end
      checks++; if ({if_gnt, mem_a} !== {1'b1, 16'h0044}) begin failures++; $display("FAIL kill_new_gnt got gnt=%b a=%h exp gnt=1 a=0044", if_gnt, mem_a); end
      tick();
      idle(); mem_rd = 32'hCAFE_0044;
      #1;
      checks++; if (if_rvld !== 1'b1) begin failures++; $display("FAIL kill_next_rvld got=%b exp=1", if_rvld); end
      checks++; if (if_rd !== 32'hCAFE_0044) begin failures++; $display("FAIL kill_next_rd got=%h exp=cafe0044", if_rd); end
      tick();
   endtask

   task automatic test_reset_mid();
      // Build up starve count 3 with LSU reads in flight, then reset.
      if_req = 1; if_a = 16'h0050;
      ls_req = 1; ls_a = 16'h0500; ls_re = 4'hF;
      tick(); tick(); tick();
      idle();
      rst = 1;
      #1;
      checks++; if ({ls_rvld, if_rvld} !== 2'b00) begin failures++; $display("FAIL rstmid_rvld got ls=%b if=%b exp 0 0", ls_rvld, if_rvld); end
      tick();
      rst = 0;
      #1;
      checks++; if ({ls_rvld, if_rvld} !== 2'b00) begin failures++; $display("FAIL rstmid_post_rvld got ls=%b if=%b exp 0 0", ls_rvld, if_rvld); end
      tick();
      // Cleared counter and ARB state: full four LSU grants before fetch.
      starve_run("rstmid");
   endtask

   initial begin
      test_reset();
      test_fetch_alone();
      test_ls_priority();
      test_starve();
      test_write();
      test_kill();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
